sdram_port_arbiter: RTL and testbench

Parametrised N-port request arbiter between the core's memory clients (main-ROM download, cartridge download, tape write, CPU, tape playback) and the single-port SDRAM controller. It replaces the combinational priority mux of address and strobe with a registered, handshaked arbiter. Each client gets a request/acknowledge pair, and the SDRAM controller sees one clean strobe per transaction. It sits between the client logic and `sdram` in the top level, all on `clk_sys`.

---
 rtl/sdram_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sdram_port_arbiter
// Brief    : Registered request/ack arbiter between N memory clients and the
//            single-port SDRAM controller. Fixed priority (port 0 highest) by
//            default; define ARB_ROUND_ROBIN_EN for rotating priority.
// Revision : 1.0  initial release
// ============================================================================
module sdram_port_arbiter #(
   parameter int NUM_PORTS  = 5,
   parameter int ADDR_WIDTH = 23,
   parameter int DATA_WIDTH = 8,
   localparam int GW        = $clog2(NUM_PORTS)
) (
   input  logic                             clk_sys,
   input  logic                             reset,
   input  logic [NUM_PORTS-1:0]             port_req,
   input  logic [NUM_PORTS-1:0]             port_we,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  port_addr,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]  port_din,
   output logic [NUM_PORTS-1:0]             port_ack,
   output logic [DATA_WIDTH-1:0]            port_dout,
   output logic                             mem_rd,
   output logic                             mem_we,
   output logic [ADDR_WIDTH-1:0]            mem_addr,
   output logic [DATA_WIDTH-1:0]            mem_din,
   input  logic [DATA_WIDTH-1:0]            mem_dout,
   input  logic                             mem_ready,
   output logic                             busy,
   output logic [GW-1:0]                    grant
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   state_t                  state_q;
   logic [NUM_PORTS-1:0]    ack_q;
   logic [DATA_WIDTH-1:0]   dout_q;
   logic                    rd_q;
   logic                    wr_q;
   logic                    we_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   din_q;
   logic                    busy_q;
   logic [GW-1:0]           grant_q;
   logic [GW-1:0]           grant_d;
   logic                    any_req;

`ifdef ARB_ROUND_ROBIN_EN
   logic [GW-1:0]           last_q;
   logic                    found;
   int                      cand;

   // Search starts one past the last winner and wraps around.
   always_comb begin
      any_req = |port_req;
      grant_d = '0;
      found   = 1'b0;
      cand    = 0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         cand = (int'(last_q) + 1 + k) % NUM_PORTS;
         if (!found && port_req[cand]) begin
            grant_d = GW'(cand);
            found   = 1'b1;
         end
      end
   end
`else
   // Scanning downward lets the lowest requesting index win.
   always_comb begin
      any_req = |port_req;
      grant_d = '0;
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         if (port_req[k]) grant_d = GW'(k);
      end
   end
`endif

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q <= S_IDLE;
         ack_q   <= '0;
         dout_q  <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         din_q   <= '0;
         busy_q  <= 1'b0;
         grant_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
         last_q  <= GW'(NUM_PORTS - 1);
`endif
      end else begin
         ack_q <= '0;
         rd_q  <= 1'b0;
         wr_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (any_req) begin
                  grant_q <= grant_d;
                  we_q    <= port_we[grant_d];
                  addr_q  <= port_addr[int'(grant_d)*ADDR_WIDTH +: ADDR_WIDTH];
                  din_q   <= port_din[int'(grant_d)*DATA_WIDTH +: DATA_WIDTH];
                  // Strobe is launched here so it is visible during ISSUE.
                  rd_q    <= ~port_we[grant_d];
                  wr_q    <= port_we[grant_d];
                  busy_q  <= 1'b1;
                  state_q <= S_ISSUE;
`ifdef ARB_ROUND_ROBIN_EN
                  last_q  <= grant_d;
`endif
               end
            end
            S_ISSUE: begin
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (mem_ready) begin
                  ack_q[grant_q] <= 1'b1;
                  if (!we_q) dout_q <= mem_dout;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign port_ack  = ack_q;
   assign port_dout = dout_q;
   assign mem_rd    = rd_q;
   assign mem_we    = wr_q;
   assign mem_addr  = addr_q;
   assign mem_din   = din_q;
   assign busy      = busy_q;
   assign grant     = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_port_arbiter
// Brief    : Directed self-checking bench for sdram_port_arbiter.
// Revision : 1.0  initial release
// ============================================================================
module tb_sdram_port_arbiter;

   localparam int NP = 5;
   localparam int AW = 23;
   localparam int DW = 8;
   localparam int GW = $clog2(NP);

   logic              clk_sys = 1'b0;
   logic              reset;
   logic [NP-1:0]     port_req;
   logic [NP-1:0]     port_we;
   logic [NP*AW-1:0]  port_addr;
   logic [NP*DW-1:0]  port_din;
   logic [NP-1:0]     port_ack;
   logic [DW-1:0]     port_dout;
   logic              mem_rd;
   logic              mem_we;
   logic [AW-1:0]     mem_addr;
   logic [DW-1:0]     mem_din;
   logic [DW-1:0]     mem_dout;
   logic              mem_ready;
   logic              busy;
   logic [GW-1:0]     grant;

   int errors = 0;
   int checks = 0;

   always #5 clk_sys = ~clk_sys;

   sdram_port_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .port_req  (port_req),
      .port_we   (port_we),
      .port_addr (port_addr),
      .port_din  (port_din),
      .port_ack  (port_ack),
      .port_dout (port_dout),
      .mem_rd    (mem_rd),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_din   (mem_din),
      .mem_dout  (mem_dout),
      .mem_ready (mem_ready),
      .busy      (busy),
      .grant     (grant)
   );

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      int exp_g;
      reset     = 1'b1;
      port_req  = '0;
      port_we   = '0;
      port_addr = '0;
      port_din  = '0;
      mem_dout  = '0;
      mem_ready = 1'b0;
      tick();
      tick();
      check("rst_ack",  32'(port_ack),  32'h0);
      check("rst_rd",   32'(mem_rd),    32'h0);
      check("rst_we",   32'(mem_we),    32'h0);
      check("rst_addr", 32'(mem_addr),  32'h0);
      check("rst_din",  32'(mem_din),   32'h0);
      check("rst_dout", 32'(port_dout), 32'h0);
      check("rst_busy", 32'(busy),      32'h0);
      check("rst_grant",32'(grant),     32'h0);
      reset = 1'b0;
      tick();

      // Single read on port 3
      port_req[3] = 1'b1;
      port_we[3]  = 1'b0;
      port_addr[3*AW +: AW] = 23'h10005;
      tick();
      check("rd_strobe", 32'(mem_rd),   32'h1);
      check("rd_nowe",   32'(mem_we),   32'h0);
      check("rd_addr",   32'(mem_addr), 32'h10005);
      check("rd_grant",  32'(grant),    32'h3);
      check("rd_busy",   32'(busy),     32'h1);
      tick();
      check("rd_strobe_1cyc", 32'(mem_rd), 32'h0);
      tick();
      mem_ready = 1'b1;
      mem_dout  = 8'hA5;
      tick();
      check("rd_ack",   32'(port_ack),  32'h08);
      check("rd_dout",  32'(port_dout), 32'hA5);
      check("rd_busy0", 32'(busy),      32'h0);
      port_req[3] = 1'b0;
      mem_ready   = 1'b0;
      tick();
      check("rd_ack_1cyc", 32'(port_ack), 32'h0);
      check("rd_no_restrobe", 32'(mem_rd), 32'h0);

      // Contention 1 vs 3, with a stale ready during ISSUE
      port_req[1] = 1'b1;
      port_req[3] = 1'b1;
      port_addr[1*AW +: AW] = 23'h00111;
      port_addr[3*AW +: AW] = 23'h00333;
      tick();
      check("pri_grant1", 32'(grant),    32'h1);
      check("pri_addr1",  32'(mem_addr), 32'h00111);
      mem_ready = 1'b1;
      mem_dout  = 8'hFF;
      tick();
      check("pri_issue_ready_ignored", 32'(port_ack), 32'h0);
      check("pri_still_busy", 32'(busy), 32'h1);
      mem_ready = 1'b0;
      tick();
      mem_ready = 1'b1;
      mem_dout  = 8'h11;
      tick();
      check("pri_ack1",  32'(port_ack),  32'h02);
      check("pri_dout1", 32'(port_dout), 32'h11);
      port_req[1] = 1'b0;
      mem_ready   = 1'b0;
      tick();
      check("pri_grant3", 32'(grant),    32'h3);
      check("pri_rd3",    32'(mem_rd),   32'h1);
      check("pri_addr3",  32'(mem_addr), 32'h00333);
      tick();
      mem_ready = 1'b1;
      mem_dout  = 8'h33;
      tick();
      check("pri_ack3",  32'(port_ack),  32'h08);
      check("pri_dout3", 32'(port_dout), 32'h33);
      port_req[3] = 1'b0;
      mem_ready   = 1'b0;
      tick();

      // Write on port 0
      port_req[0] = 1'b1;
      port_we[0]  = 1'b1;
      port_addr[0*AW +: AW] = 23'h01FFF;
      port_din[0*DW +: DW]  = 8'h3C;
      tick();
      check("wr_strobe", 32'(mem_we),   32'h1);
      check("wr_nord",   32'(mem_rd),   32'h0);
      check("wr_din",    32'(mem_din),  32'h3C);
      check("wr_addr",   32'(mem_addr), 32'h01FFF);
      tick();
      check("wr_strobe_1cyc", 32'(mem_we), 32'h0);
      mem_ready = 1'b1;
      mem_dout  = 8'hEE;
      tick();
      check("wr_ack",      32'(port_ack),  32'h01);
      check("wr_dout_keep",32'(port_dout), 32'h33);
      port_req[0] = 1'b0;
      port_we[0]  = 1'b0;
      mem_ready   = 1'b0;
      tick();

      // Reset during WAIT; request still held through the reset edge
      port_req[4] = 1'b1;
      port_addr[4*AW +: AW] = 23'h7FFFFF;
      tick();
      tick();
      check("rw_busy_wait", 32'(busy), 32'h1);
      reset = 1'b1;
      tick();
      check("rw_busy",  32'(busy),      32'h0);
      check("rw_rd",    32'(mem_rd),    32'h0);
      check("rw_addr",  32'(mem_addr),  32'h0);
      check("rw_dout",  32'(port_dout), 32'h0);
      check("rw_grant", 32'(grant),     32'h0);
      reset       = 1'b0;
      port_req[4] = 1'b0;
      mem_ready   = 1'b1;
      mem_dout    = 8'h77;
      tick();
      check("rw_no_ack",  32'(port_ack), 32'h0);
      check("rw_no_rd",   32'(mem_rd),   32'h0);
      check("rw_idle",    32'(busy),     32'h0);
      mem_ready = 1'b0;
      tick();
      check("rw_no_ack2", 32'(port_ack), 32'h0);

      // Request withdrawn during WAIT on port 2
      port_req[2] = 1'b1;
      port_addr[2*AW +: AW] = 23'h00222;
      tick();
      check("wd_grant", 32'(grant), 32'h2);
      tick();
      port_req[2] = 1'b0;
      tick();
      mem_ready = 1'b1;
      mem_dout  = 8'h5A;
      tick();
      check("wd_ack",  32'(port_ack),  32'h04);
      check("wd_dout", 32'(port_dout), 32'h5A);
      mem_ready = 1'b0;
      tick();
      check("wd_ack_once", 32'(port_ack), 32'h0);
      tick();
      check("wd_no_strobe", 32'(mem_rd), 32'h0);
      check("wd_idle",      32'(busy),   32'h0);

      // Ports 0 and 1 requesting continuously for four transactions
      port_req[0] = 1'b1;
      port_req[1] = 1'b1;
      for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
         exp_g = k % 2;
`else
         exp_g = 0;
`endif
         tick();
         check($sformatf("cont_grant%0d", k), 32'(grant), 32'(exp_g));
         check($sformatf("cont_rd%0d", k),    32'(mem_rd), 32'h1);
         tick();
         mem_ready = 1'b1;
         mem_dout  = 8'(8'h80 + k);
         tick();
         check($sformatf("cont_ack%0d", k),  32'(port_ack),  32'(1 << exp_g));
         check($sformatf("cont_dout%0d", k), 32'(port_dout), 32'(8'h80 + k));
         mem_ready = 1'b0;
         if (k == 3) port_req = '0;
      end
      tick();
      tick();
      check("cont_done_idle", 32'(busy), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
